// File: rtl/ysyx_23060124_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_23060124_lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Reserved encodings fall into the word class, so only B/BU/H/HU are narrow.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      LSU_B, LSU_BU: mis = 1'b0;
      LSU_H, LSU_HU: mis = addr_lo[0];
      LSU_W:         mis = (addr_lo != 2'b00);
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_23060124_lsu_align.sv
// Combinational load extractor/extender and store lane/strobe generator.
module ysyx_23060124_lsu_align
  import ysyx_23060124_lsu_pkg::*;
(
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data_c,
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_wdata,
  output logic [XLEN-1:0] st_data_c,
  output logic [3:0]      st_strb_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load: pick the addressed lane, then extend according to signedness.
  always_comb begin
    byte_sel  = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    half_sel  = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data_c = ld_rdata;
    case (ld_funct3)
      LSU_B:   ld_data_c = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  ld_data_c = {24'b0, byte_sel};
      LSU_H:   ld_data_c = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  ld_data_c = {16'b0, half_sel};
      LSU_W:   ld_data_c = ld_rdata;
      default: ld_data_c = ld_rdata;
    endcase
  end

  // Store: replicate data into every lane so the strobe alone selects bytes.
  always_comb begin
    st_strb_c = 4'b1111;
    st_data_c = st_wdata;
    case (st_funct3)
      LSU_B, LSU_BU: begin
        st_strb_c = 4'b0001 << st_addr_lo;
        st_data_c = {4{st_wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        st_strb_c = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_data_c = {2{st_wdata[15:0]}};
      end
      default: begin
        st_strb_c = 4'b1111;
        st_data_c = st_wdata;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_lsu.sv
// Load/store unit: single outstanding access over a req/gnt/rvalid bus,
// valid/ready toward EXU and WBU.
module ysyx_23060124_lsu
  import ysyx_23060124_lsu_pkg::*;
(
  input  logic            clock,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [4:0]      out_rd,
  output logic            out_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      strb_q, strb_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            load_q, load_d;
  logic            store_q, store_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] ld_data_c;
  logic [XLEN-1:0] st_data_c;
  logic [3:0]      st_strb_c;
  logic            resp_fire_c;

  ysyx_23060124_lsu_align u_align (
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_rdata   (mem_rdata),
    .ld_data_c  (ld_data_c),
    .st_funct3  (in_funct3),
    .st_addr_lo (in_addr[1:0]),
    .st_wdata   (in_wdata),
    .st_data_c  (st_data_c),
    .st_strb_c  (st_strb_c)
  );

  // A response counts in RESP, or in REQ when it arrives together with the grant.
  assign resp_fire_c = mem_rvalid &&
                       ((state_q == ST_RESP) || ((state_q == ST_REQ) && mem_gnt));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    funct3_d = funct3_q;
    load_d   = load_q;
    store_d  = store_q;
    rd_d     = rd_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          addr_d   = in_addr;
          funct3_d = in_funct3;
          load_d   = in_load;
          store_d  = in_store;
          rd_d     = in_rd;
          wdata_d  = in_store ? st_data_c : '0;
          strb_d   = in_store ? st_strb_c : 4'b0000;
          res_d    = '0;
          err_d    = 1'b0;
          if (!in_load && !in_store) begin
            res_d   = in_addr;
            state_d = ST_DONE;
          end else if (is_misaligned(in_funct3, in_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = mem_rvalid ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (resp_fire_c) begin
      err_d = mem_err;
      res_d = (mem_err || !load_q) ? '0 : ld_data_c;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= 4'b0000;
      funct3_q <= 3'b000;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      rd_q     <= 5'd0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      funct3_q <= funct3_d;
      load_q   <= load_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = (state_q == ST_REQ) && store_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = strb_q;
  assign out_res   = res_q;
  assign out_rd    = rd_q;
  assign out_err   = err_q;

endmodule
